muldiv: RTL and testbench
=========================

# muldiv

Iterative multiply/divide unit that produces the HI/LO results for MULT, MULTU, DIV and DIVU. It sits in the execute stage and drives the HI/LO register file's `hi_data`/`lo_data`/`hi_write`/`lo_write` inputs. It stalls the pipeline through `busy` while an operation is in flight. It is the write-side counterpart of the HI/LO register file: that block stores and forwards results, this block computes and commits them.

## Interface
Parameters: none. Divider width is fixed at 32; iteration count is fixed at 32.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `resetn`  in  1  one clock; reset is synchronous and active-low
- `in_valid`  in  1  request present this cycle
- `in_ready`  out  1  unit can accept; `(state == IDLE) && !flush`
- `op`  in  2  operation: `MULT`=0, `MULTU`=1, `DIV`=2, `DIVU`=3
- `a`  in  32  rs operand (multiplicand / dividend)
- `b`  in  32  rt operand (multiplier / divisor)
- `flush`  in  1  abort in-flight operation, suppress its write
- `busy`  out  1  `state != IDLE`
- `hi_data`  out  32  HI result (product[63:32] / remainder)
- `lo_data`  out  32  LO result (product[31:0] / quotient)
- `hi_write`  out  1  commit `hi_data` this cycle
- `lo_write`  out  1  commit `lo_data` this cycle

## Operation
- States: `IDLE`, `MUL`, `DIV`, `DONE`.
- `IDLE`:
  - Accept when `in_valid && in_ready`; latch `op`, `a`, `b`.
  - `MULT`/`MULTU` go to `MUL`.
  - `DIV`/`DIVU` go to `DIV`; iteration counter cleared to 0.
- `MUL`:
  - 64-bit product of the latched operands: signed×signed for `MULT`, unsigned×unsigned for `MULTU`.
  - Product registered into the result register; next state `DONE`.
- `DIV`:
  - Restoring division on magnitudes; operands are treated as signed for `DIV` and unsigned for `DIVU`.
  - One quotient bit per cycle; counter runs 0..31.
  - On counter 31, sign fixup is registered and the state goes to `DONE`:
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
- `DONE`:
  - `hi_write = lo_write = 1` for exactly one cycle; `hi_data`/`lo_data` come from the result register.
  - Next state `IDLE`.
- `hi_data`/`lo_data` hold the last result when the state is not `DONE`.
- Divide by zero (`b == 0`): `lo = 32'hFFFFFFFF`, `hi = a`, for both signed and unsigned. No exception is raised and latency is unchanged.
- `DIV` of `32'h80000000` by `32'hFFFFFFFF`: `lo = 32'h80000000`, `hi = 0`. No trap.
- `flush`:
  - In any state, the next state is `IDLE`.
  - In `DONE`, `hi_write`/`lo_write` are forced to 0 that cycle.
  - `in_valid` in a flush cycle is ignored.
- No request is accepted in `DONE`. Back-to-back requests are accepted on the first `IDLE` cycle after `DONE`.

## Timing
- Reset (`resetn` low at an edge):
  - State goes to `IDLE` and the counter to 0.
  - Result register goes to 0, so `hi_data = lo_data = 0`.
  - `hi_write = lo_write = 0` and `busy = 0`.
  - `in_ready` is 1 once `resetn` is high.
- Reset mid-operation discards the operation; no write is produced.
- Latency, with the request accepted in cycle c:
  - MUL: `MUL` in cycle c+1; write strobes in cycle c+2.
  - DIV: `DIV` in cycles c+1..c+32; write strobes in cycle c+33.
- `busy` is high from cycle c+1 through the `DONE` cycle inclusive.
- The downstream HI/LO file bypasses its write, so a read in the `DONE` cycle already sees the new value.
- Outputs are derived from registered state only; there is no combinational path from `a`/`b` to any output.

## Structure
- Shared package holds:
  - `muldiv_op_t` (2-bit enum, values above)
  - `muldiv_state_t` (`IDLE`, `MUL`, `DIV`, `DONE`)
  - `DIV_ITERS = 32`
  - the existing `i32` typedef, used for all 32-bit signals
- One sub-module: `divu32`, the unsigned restoring divider step.
  - Inputs: 64-bit partial-remainder/quotient register and the divisor magnitude.
  - Output: the next register value.
  - Purely combinational; `muldiv` owns the iteration register, counter and sign handling.
- Multiplier is inferred `*` on sign/zero-extended 33-bit operands, truncated to 64 bits.

## Test plan
- `MULT a=32'hFFFFFFFF b=2` → cycle c+2: `hi=32'hFFFFFFFF lo=32'hFFFFFFFE`, strobes high 1 cycle. `MULTU` with the same operands → `hi=1 lo=32'hFFFFFFFE`.
- `DIVU a=100 b=7` → cycle c+33: `lo=14 hi=2`; `busy` high c+1..c+33; `in_ready` low c+1..c+33.
- `DIV a=-7 (32'hFFFFFFF9) b=2` → `lo=32'hFFFFFFFD hi=32'hFFFFFFFF`. `DIV a=32'h80000000 b=32'hFFFFFFFF` → `lo=32'h80000000 hi=0`.
- Divide by zero: `DIV a=5 b=0` → `lo=32'hFFFFFFFF hi=5` at c+33.
- `flush` in cycle c+10 of a `DIV` → `IDLE` at c+11, no strobes ever. New `MULTU 3×4` accepted at c+11 → `lo=12 hi=0` at c+13.
- `flush` in the `DONE` cycle → strobes 0. `resetn` low mid-`DIV` → all outputs 0 next cycle, no write. Two back-to-back `MULT`s → second accepted the cycle after the first `DONE`.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the iterative multiply/divide unit.
//   i32            - 32-bit data word used for every 32-bit signal
//   muldiv_op_t    - operation encoding (MULT=0, MULTU=1, DIV=2, DIVU=3)
//   muldiv_state_t - control FSM states
//   DIV_ITERS      - number of restoring-division iterations
//   magnitude()    - absolute value of a word, treated as signed or unsigned
package muldiv_pkg;

  typedef logic [31:0] i32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

  localparam int DIV_ITERS = 32;

  // Two's-complement magnitude. The most negative value maps onto itself,
  // which is exactly 2^31 when read back as unsigned.
  function automatic i32 magnitude(input i32 x, input logic is_signed);
    return (is_signed && x[31]) ? -x : x;
  endfunction

endpackage

// File: rtl/divu32.sv
// divu32: one step of an unsigned restoring divider (purely combinational).
//   rq      in  64  {partial remainder, dividend/quotient shift register}
//   divisor in  32  divisor magnitude
//   rq_next out 64  register value after this step; the new quotient bit
//                   enters at bit 0
module divu32
  import muldiv_pkg::*;
(
  input  logic [63:0] rq,
  input  i32          divisor,
  output logic [63:0] rq_next
);

  logic [32:0] trial;
  logic        fits;
  i32          rem_trial;

  // The shifted remainder can be 33 bits wide (remainder < divisor <= 2^32-1),
  // so the compare uses the bit shifted out of the top.
  always_comb begin
    trial     = rq[63:31];
    fits      = trial >= {1'b0, divisor};
    rem_trial = trial[31:0] - divisor;
    rq_next   = fits ? {rem_trial, rq[30:0], 1'b1}
                     : {trial[31:0], rq[30:0], 1'b0};
  end

endmodule

// File: rtl/muldiv.sv
// muldiv: iterative MULT/MULTU/DIV/DIVU unit producing HI/LO results.
//   clk       in   1  clock, rising edge
//   resetn    in   1  synchronous active-low reset
//   in_valid  in   1  request present
//   in_ready  out  1  request can be accepted (IDLE and no flush)
//   op        in   2  MULT=0, MULTU=1, DIV=2, DIVU=3
//   a, b      in  32  rs / rt operands
//   flush     in   1  abort in-flight operation and suppress its write
//   busy      out  1  operation in flight (state != IDLE)
//   hi_data   out 32  product[63:32] / remainder
//   lo_data   out 32  product[31:0]  / quotient
//   hi_write  out  1  commit hi_data this cycle
//   lo_write  out  1  commit lo_data this cycle
// Latency from acceptance in cycle c: multiply strobes at c+2, divide at c+33.
module muldiv
  import muldiv_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] op,
  input  i32         a,
  input  i32         b,
  input  logic       flush,
  output logic       busy,
  output i32         hi_data,
  output i32         lo_data,
  output logic       hi_write,
  output logic       lo_write
);

  muldiv_state_t state, state_next;

  muldiv_op_t  op_q;
  i32          a_q, b_q;
  i32          div_mag;
  logic [63:0] rq, rq_next;
  logic [4:0]  cnt;
  logic [63:0] result;

  logic              accept;
  logic              last_iter;
  logic              signed_op;
  logic signed [32:0] mul_a, mul_b;
  logic [63:0]       product;
  i32                quo_fix, rem_fix;

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == 5'(DIV_ITERS - 1));
  // MULT and DIV (even encodings) are the signed operations.
  assign signed_op = !op_q[0];

  // ---------------- control FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // NOTE: defaults are assigned first so no path leaves state_next
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = op[1] ? DIV : MUL;
      MUL:  state_next = DONE;
      DIV:  if (last_iter) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // ---------------- datapath ----------------
  // Sign/zero extension to 33 bits lets one signed multiplier serve both
  // MULT and MULTU; only the low 64 bits of the product are meaningful.
  assign mul_a   = {signed_op & a_q[31], a_q};
  assign mul_b   = {signed_op & b_q[31], b_q};
  assign product = 64'(mul_a) * 64'(mul_b);

  divu32 u_divu32 (
    .rq      (rq),
    .divisor (div_mag),
    .rq_next (rq_next)
  );

  // Sign fixup on the final step. A zero divisor forces an all-ones
  // quotient even for signed operands; the remainder is already |a| and
  // re-signing it restores a. The 0x80000000 / -1 case needs no special
  // handling: the magnitude quotient 2^31 negates onto itself.
  always_comb begin
    rem_fix = (signed_op && a_q[31]) ? -rq_next[63:32] : rq_next[63:32];
    if (b_q == '0)
      quo_fix = '1;
    else if (signed_op && (a_q[31] ^ b_q[31]))
      quo_fix = -rq_next[31:0];
    else
      quo_fix = rq_next[31:0];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      op_q    <= OP_MULT;
      a_q     <= '0;
      b_q     <= '0;
      div_mag <= '0;
      rq      <= '0;
      cnt     <= '0;
      result  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            op_q    <= muldiv_op_t'(op);
            a_q     <= a;
            b_q     <= b;
            rq      <= {32'd0, magnitude(a, !op[0])};
            div_mag <= magnitude(b, !op[0]);
            cnt     <= '0;
          end
        end
        MUL: begin
          if (!flush) result <= product;
        end
        DIV: begin
          if (!flush) begin
            rq  <= rq_next;
            cnt <= cnt + 5'd1;
            if (last_iter) result <= {rem_fix, quo_fix};
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  assign in_ready = (state == IDLE) && !flush;
  assign busy     = (state != IDLE);
  assign hi_write = (state == DONE) && !flush;
  assign lo_write = (state == DONE) && !flush;
  assign hi_data  = result[63:32];
  assign lo_data  = result[31:0];

endmodule

// File: tb/tb_muldiv.sv
// tb_muldiv: self-checking bench for muldiv. Directed vectors from a table,
// randomized operations against an arithmetic reference model, and
// hand-written sequences for flush, reset and back-to-back behaviour.
module tb_muldiv;
  import muldiv_pkg::*;

  logic       clk      = 1'b0;
  logic       resetn   = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush    = 1'b0;
  logic [1:0] op       = 2'd0;
  i32         a        = '0;
  i32         b        = '0;
  logic       in_ready, busy, hi_write, lo_write;
  i32         hi_data, lo_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  muldiv dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .hi_data  (hi_data),
    .lo_data  (lo_data),
    .hi_write (hi_write),
    .lo_write (lo_write)
  );

  typedef struct {
    logic [1:0] op;
    i32         a;
    i32         b;
    i32         hi;
    i32         lo;
    int         lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {hi, lo} straight from the arithmetic definition.
  function automatic logic [63:0] ref_model(input logic [1:0] o, input i32 x, input i32 y);
    int sx, sy, sq, sr;
    longint sp;
    longint unsigned ux, uy;
    sx = x;
    sy = y;
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: begin
        sp = longint'(sx) * longint'(sy);
        return sp;
      end
      2'd1: return ux * uy;
      2'd2: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sq = sx / sy;
        sr = sx % sy;
        return {sr, sq};
      end
      default: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Issue one request in the current (idle) cycle and follow it to its
  // write strobe. Called just after a rising edge.
  task automatic run_op(input string name, input logic [1:0] o, input i32 x, input i32 y,
                        output i32 rhi, output i32 rlo, output int lat);
    logic in_flight_ok;
    check({name, " ready_at_issue"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    tick();
    // Scramble the inputs: the unit must work from its latched copies.
    in_valid = 1'b0;
    op = 2'($urandom);
    a  = $urandom;
    b  = $urandom;
    lat = 1;
    in_flight_ok = 1'b1;
    while (hi_write !== 1'b1 && lat < 60) begin
      if (busy !== 1'b1 || in_ready !== 1'b0 || lo_write !== 1'b0) in_flight_ok = 1'b0;
      tick();
      lat++;
    end
    check({name, " busy_ready_in_flight"}, in_flight_ok, 1'b1);
    check({name, " done_busy_lo_write"}, {busy, lo_write}, 2'b11);
    rhi = hi_data;
    rlo = lo_data;
    tick();
    check({name, " strobe_one_cycle"}, {hi_write, lo_write, busy, in_ready}, 4'b0001);
    check({name, " result_held"}, {hi_data, lo_data}, {rhi, rlo});
  endtask

  task automatic watch_no_strobe(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (hi_write || lo_write) seen++;
      tick();
    end
    check(name, seen, 0);
  endtask

  vec_t vecs[12];
  i32   rhi, rlo;
  int   lat;

  initial begin
    vecs[0]  = '{2'd0, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFE, 2};
    vecs[1]  = '{2'd1, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'hFFFF_FFFE, 2};
    vecs[2]  = '{2'd3, 32'd100,       32'd7,        32'd2,         32'd14,        33};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[4]  = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 33};
    vecs[5]  = '{2'd2, 32'd5,         32'd0,        32'd5,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{2'd3, 32'hFFFF_FFFF, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[7]  = '{2'd2, 32'h8000_0001, 32'd0,        32'h8000_0001, 32'hFFFF_FFFF, 33};
    vecs[8]  = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        2};
    vecs[9]  = '{2'd3, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 33};
    vecs[10] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 33};
    vecs[11] = '{2'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,        33};

    // ---- reset state ----
    tick();
    tick();
    check("reset_outputs", {hi_data, lo_data, hi_write, lo_write, busy}, '0);
    resetn = 1'b1;
    #1;
    check("ready_after_reset", {in_ready, busy}, 2'b10);
    tick();

    // ---- directed table ----
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, rhi, rlo, lat);
      check($sformatf("vec%0d hi", i), rhi, vecs[i].hi);
      check($sformatf("vec%0d lo", i), rlo, vecs[i].lo);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
    end

    // ---- randomized against the reference model ----
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      i32          x, y;
      logic [63:0] exp;
      o = 2'($urandom_range(0, 3));
      x = $urandom;
      y = $urandom;
      if (i % 8 == 3) y = '0;
      if (i % 8 == 5) y = $urandom_range(1, 15);
      if (i % 8 == 6) x = $urandom_range(0, 100);
      exp = ref_model(o, x, y);
      run_op($sformatf("rnd%0d", i), o, x, y, rhi, rlo, lat);
      check($sformatf("rnd%0d op%0d %h/%h", i, o, x, y), {rhi, rlo}, exp);
      check($sformatf("rnd%0d latency", i), lat, (o[1] ? 33 : 2));
    end

    // ---- back-to-back MULTs: second issued on the first IDLE after DONE ----
    run_op("b2b_first", 2'd0, 32'd6, 32'hFFFF_FFFD, rhi, rlo, lat);
    check("b2b_first result", {rhi, rlo}, 64'hFFFF_FFFF_FFFF_FFEE);
    run_op("b2b_second", 2'd0, 32'd9, 32'd9, rhi, rlo, lat);
    check("b2b_second result", {rhi, rlo}, 64'd81);
    check("b2b_second latency", lat, 2);

    // ---- flush in cycle c+10 of a DIV, then MULTU 3x4 at c+11 ----
    in_valid = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;   // cycle c
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();                     // now c+10
    check("flush_div busy_c10", busy, 1'b1);
    flush = 1'b1;
    #1;
    check("flush_div ready_low", in_ready, 1'b0);
    tick();                                                 // c+11
    flush = 1'b0;
    #1;
    check("flush_div idle_c11", {busy, in_ready}, 2'b01);
    in_valid = 1'b1; op = 2'd1; a = 32'd3; b = 32'd4;
    tick();                                                 // c+12
    in_valid = 1'b0;
    check("after_flush mul_busy", {busy, hi_write}, 2'b10);
    tick();                                                 // c+13
    check("after_flush strobes", {hi_write, lo_write}, 2'b11);
    check("after_flush result", {hi_data, lo_data}, 64'd12);
    tick();
    watch_no_strobe("flush_div no_late_write", 40);

    // ---- flush in the DONE cycle suppresses the write ----
    in_valid = 1'b1; op = 2'd1; a = 32'd5; b = 32'd5;
    tick();
    in_valid = 1'b0;
    tick();                                                 // DONE cycle
    flush = 1'b1;
    #1;
    check("flush_done strobes", {hi_write, lo_write}, 2'b00);
    tick();
    flush = 1'b0;
    #1;
    check("flush_done idle", {busy, hi_write, lo_write, in_ready}, 4'b0001);
    watch_no_strobe("flush_done no_write", 5);

    // ---- in_valid during a flush cycle is ignored ----
    flush = 1'b1; in_valid = 1'b1; op = 2'd3; a = 32'd9; b = 32'd2;
    #1;
    check("flush_idle ready_low", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_idle not_accepted", busy, 1'b0);
    watch_no_strobe("flush_idle no_write", 40);

    // ---- reset in the middle of a DIV ----
    run_op("pre_reset", 2'd1, 32'd7, 32'd11, rhi, rlo, lat);
    check("pre_reset result", {rhi, rlo}, 64'd77);
    in_valid = 1'b1; op = 2'd3; a = 32'd50; b = 32'd5;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    resetn = 1'b0;
    tick();
    check("reset_mid_div outputs", {hi_data, lo_data, hi_write, lo_write, busy}, '0);
    resetn = 1'b1;
    #1;
    check("reset_mid_div ready", in_ready, 1'b1);
    watch_no_strobe("reset_mid_div no_write", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
